ddc_acc_seq: RTL and testbench

Parametrised accumulator and sequentializer for the multi-channel DDC. It integrates `N_CH` complex DDC outputs over a programmable number of samples and snapshots all channel sums at the frame boundary. It then drains them one channel per beat onto a single AXI-Stream output with real `tready` backpressure, channel tagging and frame-drop accounting. It sits between the per-channel `ddc_oct` outputs and the host-side DMA/stream path, on the data-converter clock.

---
 rtl/ddc_acc_pkg.sv | 42 ++++
 rtl/ddc_acc_lane.sv | 58 +++++
 rtl/ddc_acc_seq.sv | 140 ++++++++++++++
 tb/tb_ddc_acc_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_acc_pkg.sv
// Shared types and helpers for the DDC accumulator/sequentializer.
// DDC_ACC_SAT_EN selects saturating accumulation instead of wrap-around.
package ddc_acc_pkg;

    // Working width for the add helper; comfortably above any supported ACC_WIDTH.
    localparam int ACC_MAX_W = 128;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operands arrive sign-extended; the result is the acc_w-bit lane value, sign-extended.
    function automatic logic signed [ACC_MAX_W-1:0] acc_add(
        input logic signed [ACC_MAX_W-1:0] sum,
        input logic signed [ACC_MAX_W-1:0] sample,
        input int                          acc_w
    );
        logic signed [ACC_MAX_W-1:0] raw;
`ifdef DDC_ACC_SAT_EN
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        raw = sum + sample;
        lo  = {ACC_MAX_W{1'b1}} <<< (acc_w - 1);
        hi  = ~lo;
        if (raw > hi) begin
            return hi;
        end else if (raw < lo) begin
            return lo;
        end
        return raw;
`else
        raw = sum + sample;
        return (raw <<< (ACC_MAX_W - acc_w)) >>> (ACC_MAX_W - acc_w);
`endif
    endfunction

endpackage

// File: rtl/ddc_acc_lane.sv
// One signed accumulator lane (I or Q of a channel) with clear-on-frame-end.
// DDC_ACC_SAT_EN adds a sticky clamp flag so a saturated lane holds until cleared.
module ddc_acc_lane
    import ddc_acc_pkg::*;
#(
    parameter int DDC_WIDTH = 32,
    parameter int ACC_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic signed [DDC_WIDTH-1:0] sample,
    output logic signed [ACC_WIDTH-1:0] frame_sum
);

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] sum_next;
`ifdef DDC_ACC_SAT_EN
    logic                        sat_q, sat_d;
    logic signed [ACC_MAX_W-1:0] raw, clamped;
`endif

    always_comb begin
`ifdef DDC_ACC_SAT_EN
        raw      = ACC_MAX_W'(acc_q) + ACC_MAX_W'(sample);
        clamped  = acc_add(ACC_MAX_W'(acc_q), ACC_MAX_W'(sample), ACC_WIDTH);
        sum_next = sat_q ? acc_q : ACC_WIDTH'(clamped);
        sat_d    = sat_q;
        if (en) begin
            sat_d = clr ? 1'b0 : (sat_q || (clamped != raw));
        end
`else
        sum_next = ACC_WIDTH'(acc_add(ACC_MAX_W'(acc_q), ACC_MAX_W'(sample), ACC_WIDTH));
`endif
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? '0 : sum_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
`ifdef DDC_ACC_SAT_EN
            sat_q <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
`ifdef DDC_ACC_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

    assign frame_sum = sum_next;

endmodule

// File: rtl/ddc_acc_seq.sv
// Multi-channel DDC integrator: snapshots all channel sums per frame and drains them
// one channel per AXI-Stream beat. DDC_ACC_SAT_EN enables saturating lanes.
module ddc_acc_seq
    import ddc_acc_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DDC_WIDTH = 32,
    parameter int ACC_WIDTH = 48,
    parameter int LEN_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH*2*DDC_WIDTH-1:0]   s_ddc_tdata,
    input  logic                          s_ddc_tvalid,
    input  logic [LEN_WIDTH-1:0]          acc_len,
    output logic [2*ACC_WIDTH-1:0]        m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [ch_width(N_CH)-1:0]     m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          frame_drop,
    output logic [15:0]                   drop_cnt
);

    localparam int              CH_W    = ch_width(N_CH);
    localparam int              BEAT_W  = 2*ACC_WIDTH;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH-1);

    drain_state_e                state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d, ch_next;
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;
    logic [BEAT_W-1:0]           tdata_q, tdata_d;
    logic                        drop_q, drop_d;
    logic [15:0]                 drop_cnt_q, drop_cnt_d;
    logic [BEAT_W-1:0]           shadow_q [N_CH];
    logic [BEAT_W-1:0]           shadow_d [N_CH];
    logic [BEAT_W-1:0]           snap_beat [N_CH];
    logic [LEN_WIDTH-1:0]        len_q, len_d, cnt_q, cnt_d, len_next;
    logic signed [ACC_WIDTH-1:0] lane_sum [2*N_CH];
    logic                        frame_end, hs, bank_free, snap;

    assign len_next  = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
    assign frame_end = s_ddc_tvalid && (cnt_q == len_q - LEN_WIDTH'(1));

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        ddc_acc_lane #(.DDC_WIDTH(DDC_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_i (
            .clk       (clk),
            .rst       (rst),
            .en        (s_ddc_tvalid),
            .clr       (frame_end),
            .sample    (s_ddc_tdata[2*DDC_WIDTH*k +: DDC_WIDTH]),
            .frame_sum (lane_sum[2*k])
        );
        ddc_acc_lane #(.DDC_WIDTH(DDC_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_q (
            .clk       (clk),
            .rst       (rst),
            .en        (s_ddc_tvalid),
            .clr       (frame_end),
            .sample    (s_ddc_tdata[2*DDC_WIDTH*k+DDC_WIDTH +: DDC_WIDTH]),
            .frame_sum (lane_sum[2*k+1])
        );
        assign snap_beat[k] = {lane_sum[2*k+1], lane_sum[2*k]};
    end

    // The bank frees up in the very cycle its last beat is accepted, so back-to-back frames are lossless.
    always_comb begin
        hs        = tvalid_q && m_axis_tready;
        bank_free = (state_q == IDLE) || (hs && tlast_q);
        snap      = frame_end && bank_free;
        ch_next   = ch_q + CH_W'(1);

        cnt_d = cnt_q;
        if (s_ddc_tvalid) begin
            cnt_d = frame_end ? '0 : cnt_q + LEN_WIDTH'(1);
        end
        len_d      = frame_end ? len_next : len_q;
        drop_d     = frame_end && !bank_free;
        drop_cnt_d = (drop_d && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

        shadow_d = shadow_q;
        state_d  = state_q;
        ch_d     = ch_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;

        if (snap) begin
            shadow_d = snap_beat;
            state_d  = DRAIN;
            ch_d     = '0;
            tvalid_d = 1'b1;
            tdata_d  = snap_beat[0];
            tlast_d  = (LAST_CH == '0);
        end else if (hs) begin
            if (!tlast_q) begin
                ch_d    = ch_next;
                tdata_d = shadow_q[ch_next];
                tlast_d = (ch_next == LAST_CH);
            end else begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            shadow_q   <= '{default: '0};
            cnt_q      <= '0;
            len_q      <= len_next;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = ch_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_drop    = drop_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_ddc_acc_seq.sv
// Directed bench for ddc_acc_seq with a narrow accumulator (ACC_WIDTH = DDC_WIDTH+1)
// so overflow behaviour is reachable; expectations follow DDC_ACC_SAT_EN.
module tb_ddc_acc_seq;

    localparam int N_CH = 4;
    localparam int DW   = 16;
    localparam int AW   = 17;
    localparam int LW   = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH*2*DW-1:0]   s_tdata;
    logic                   s_tvalid;
    logic [LW-1:0]          acc_len;
    logic [2*AW-1:0]        m_tdata;
    logic                   m_tvalid;
    logic                   m_tready;
    logic [1:0]             m_tuser;
    logic                   m_tlast;
    logic                   frame_drop;
    logic [15:0]            drop_cnt;
    logic [2*AW+3:0]        obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign obs = {m_tvalid, m_tuser, m_tlast, m_tdata};

    ddc_acc_seq #(
        .N_CH      (N_CH),
        .DDC_WIDTH (DW),
        .ACC_WIDTH (AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_ddc_tdata   (s_tdata),
        .s_ddc_tvalid  (s_tvalid),
        .acc_len       (acc_len),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .frame_drop    (frame_drop),
        .drop_cnt      (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel k gets I = base*(k+1), Q = -base*(k+1).
    task automatic drive(input logic v, input int base);
        s_tvalid = v;
        for (int k = 0; k < N_CH; k++) begin
            s_tdata[2*DW*k +: DW]    = DW'(base*(k+1));
            s_tdata[2*DW*k+DW +: DW] = DW'(-base*(k+1));
        end
    endtask

    function automatic logic [2*AW+3:0] beat(input int ch, input int isum, input int qsum);
        return {1'b1, 2'(ch), (ch == N_CH-1), qsum[AW-1:0], isum[AW-1:0]};
    endfunction

    task automatic apply_reset(input int len);
        rst      = 1'b1;
        m_tready = 1'b1;
        acc_len  = LW'(len);
        drive(1'b0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_stream: got %h expected 0", obs);
        end
        n_tests++;
        if ({frame_drop, drop_cnt} !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_drop: got %h expected 0", {frame_drop, drop_cnt});
        end
    endtask

    task automatic test_basic();
        apply_reset(3);
        drive(1'b1, 1);
        repeat (3) tick();
        drive(1'b0, 0);
        for (int k = 0; k < N_CH; k++) begin
            n_tests++;
            if (obs !== beat(k, 3*(k+1), -3*(k+1))) begin
                n_fail++;
                $display("[TB] FAIL basic_beat%0d: got %h expected %h", k, obs, beat(k, 3*(k+1), -3*(k+1)));
            end
            n_tests++;
            if (frame_drop !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL basic_drop%0d: got %b expected 0", k, frame_drop);
            end
            tick();
        end
        n_tests++;
        if (m_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_idle: got tvalid %b expected 0", m_tvalid);
        end
    endtask

    // Every sample closes a frame; a 4-beat drain cannot keep up, so 3 of every 4 frames drop.
    task automatic test_zero_len();
        int eu[6] = '{0, 1, 2, 3, 0, 1};
        int ed[6] = '{0, 1, 1, 1, 0, 1};
        int ec[6] = '{0, 1, 2, 3, 3, 4};
        apply_reset(0);
        drive(1'b1, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (obs !== beat(eu[i], eu[i]+1, -(eu[i]+1))) begin
                n_fail++;
                $display("[TB] FAIL zero_len_beat%0d: got %h expected %h", i, obs, beat(eu[i], eu[i]+1, -(eu[i]+1)));
            end
            n_tests++;
            if ({frame_drop, drop_cnt} !== {ed[i][0], ec[i][15:0]}) begin
                n_fail++;
                $display("[TB] FAIL zero_len_drop%0d: got %b/%0d expected %0d/%0d", i, frame_drop, drop_cnt, ed[i], ec[i]);
            end
        end
        drive(1'b0, 0);
        repeat (3) tick();
        n_tests++;
        if ({m_tvalid, drop_cnt} !== {1'b0, 16'd4}) begin
            n_fail++;
            $display("[TB] FAIL zero_len_end: got tvalid %b cnt %0d expected 0/4", m_tvalid, drop_cnt);
        end
    endtask

    // Stalled beats must hold; the frame ending while ch2 waits is dropped, in-flight data untouched.
    task automatic test_backpressure();
        int tr[10] = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 1};
        int eu[10] = '{0, 1, 1, 2, 2, 2, 2, 2, 3, 4};
        int ed[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        apply_reset(8);
        drive(1'b1, 2);
        repeat (8) tick();
        n_tests++;
        if (obs !== beat(0, 16, -16)) begin
            n_fail++;
            $display("[TB] FAIL bp_first: got %h expected %h", obs, beat(0, 16, -16));
        end
        drive(1'b1, 5);
        for (int i = 0; i < 10; i++) begin
            m_tready = tr[i][0];
            if (i == 8) drive(1'b0, 0);
            tick();
            n_tests++;
            if (eu[i] == 4) begin
                if (m_tvalid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL bp_idle: got tvalid %b expected 0", m_tvalid);
                end
            end else if (obs !== beat(eu[i], 16*(eu[i]+1), -16*(eu[i]+1))) begin
                n_fail++;
                $display("[TB] FAIL bp_beat%0d: got %h expected %h", i, obs, beat(eu[i], 16*(eu[i]+1), -16*(eu[i]+1)));
            end
            n_tests++;
            if (frame_drop !== ed[i][0]) begin
                n_fail++;
                $display("[TB] FAIL bp_drop%0d: got %b expected %0d", i, frame_drop, ed[i]);
            end
        end
        n_tests++;
        if (drop_cnt !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL bp_drop_cnt: got %0d expected 1", drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int eu[8] = '{1, 2, 3, 0, 1, 2, 3, 4};
        int eb[8] = '{1, 1, 1, 3, 3, 3, 3, 0};
        apply_reset(4);
        drive(1'b1, 1);
        repeat (4) tick();
        n_tests++;
        if (obs !== beat(0, 4, -4)) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got %h expected %h", obs, beat(0, 4, -4));
        end
        drive(1'b1, 3);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) drive(1'b0, 0);
            tick();
            n_tests++;
            if (eu[i] == 4) begin
                if (m_tvalid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_idle: got tvalid %b expected 0", m_tvalid);
                end
            end else if (obs !== beat(eu[i], 4*eb[i]*(eu[i]+1), -4*eb[i]*(eu[i]+1))) begin
                n_fail++;
                $display("[TB] FAIL b2b_beat%0d: got %h expected %h", i, obs, beat(eu[i], 4*eb[i]*(eu[i]+1), -4*eb[i]*(eu[i]+1)));
            end
            n_tests++;
            if ({frame_drop, drop_cnt} !== 17'd0) begin
                n_fail++;
                $display("[TB] FAIL b2b_drop%0d: got %b/%0d expected 0/0", i, frame_drop, drop_cnt);
            end
        end
    endtask

    // I = +max and Q = -min on every channel for 4 samples overflows a 17-bit lane both ways.
    task automatic test_saturation();
        int ei, eq;
`ifdef DDC_ACC_SAT_EN
        ei = 65535;
        eq = -65536;
`else
        ei = -4;
        eq = 0;
`endif
        apply_reset(4);
        for (int k = 0; k < N_CH; k++) begin
            s_tdata[2*DW*k +: DW]    = 16'h7FFF;
            s_tdata[2*DW*k+DW +: DW] = 16'h8000;
        end
        s_tvalid = 1'b1;
        repeat (4) tick();
        drive(1'b0, 0);
        for (int k = 0; k < N_CH; k++) begin
            n_tests++;
            if (obs !== beat(k, ei, eq)) begin
                n_fail++;
                $display("[TB] FAIL sat_beat%0d: got %h expected %h", k, obs, beat(k, ei, eq));
            end
            tick();
        end
        n_tests++;
        if (m_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sat_idle: got tvalid %b expected 0", m_tvalid);
        end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset(5);
        drive(1'b1, 1);
        repeat (5) tick();
        drive(1'b0, 0);
        tick();
        n_tests++;
        if (obs !== beat(1, 10, -10)) begin
            n_fail++;
            $display("[TB] FAIL mid_pre: got %h expected %h", obs, beat(1, 10, -10));
        end
        rst     = 1'b1;
        acc_len = LW'(2);
        tick();
        n_tests++;
        if ({obs, frame_drop, drop_cnt} !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got %h expected 0", {obs, frame_drop, drop_cnt});
        end
        rst = 1'b0;
        drive(1'b1, 2);
        tick();
        n_tests++;
        if (m_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_early: got tvalid %b expected 0", m_tvalid);
        end
        tick();
        drive(1'b0, 0);
        for (int k = 0; k < N_CH; k++) begin
            n_tests++;
            if (obs !== beat(k, 4*(k+1), -4*(k+1))) begin
                n_fail++;
                $display("[TB] FAIL mid_beat%0d: got %h expected %h", k, obs, beat(k, 4*(k+1), -4*(k+1)));
            end
            tick();
        end
        n_tests++;
        if (m_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_idle: got tvalid %b expected 0", m_tvalid);
        end
    endtask

    initial begin
        rst      = 1'b1;
        m_tready = 1'b1;
        acc_len  = '0;
        drive(1'b0, 0);
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
